// File: rtl/dshot_pkg.sv
// Shared definitions for the DShot frame controller.
//   dshotState_t      : controller FSM states
//   CMD_* constants   : special command codes carried in the 6-bit cmd field
//   THROTTLE_MAX      : largest legal throttle value after the -48 offset
//   clampThrottle()   : limits a decoded speed to THROTTLE_MAX
package dshot_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAILSAFE = 2'd2
    } dshotState_t;

    localparam logic [5:0]  CMD_STOP          = 6'd0;
    localparam logic [5:0]  CMD_SPIN_NORMAL   = 6'd7;
    localparam logic [5:0]  CMD_SPIN_REVERSED = 6'd8;
    localparam logic [5:0]  CMD_MAX           = 6'd47;
    localparam logic [10:0] THROTTLE_MAX      = 11'd1999;

    function automatic logic [10:0] clampThrottle(input logic [10:0] v);
        return (v > THROTTLE_MAX) ? THROTTLE_MAX : v;
    endfunction

endpackage

// File: rtl/dshot_timeout_timer.sv
// Link-loss timer for the frame controller.
//   clk     : clock
//   clear   : synchronous clear (reset, accepted frame, or not armed)
//   enable  : count one cycle when not cleared
//   expired : high in the cycle whose increment would reach TIMEOUT_CYCLES
// The count holds at TIMEOUT_CYCLES-1 instead of running on; the controller
// leaves ARMED on expiry, which clears the timer on the following edge.
module dshot_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1600000
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + CW'(1);
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/dshot_frame_controller.sv
// DShot frame controller: arming, throttle, link-loss failsafe and
// repeated-command execution from decoded DShot frames.
//   clk, reset                  : clock, synchronous active-high reset
//   frame_valid, crc_valid      : frame strobe and CRC status
//   is_special, speed_in,
//   cmd_in, telem_in            : decoded frame fields
//   throttle, armed, failsafe   : motor command and FSM status
//   cmd_strobe, cmd_code        : executed-command pulse and held code
//   spin_reversed               : spin-direction flag (cmd 7 / cmd 8)
//   telem_request               : pulse per accepted frame asking for telemetry
module dshot_frame_controller
    import dshot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1600000,
    parameter int ARM_FRAMES     = 50,
    parameter int CMD_REPEAT     = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic        crc_valid,
    input  logic        is_special,
    input  logic [10:0] speed_in,
    input  logic [5:0]  cmd_in,
    input  logic        telem_in,
    output logic [10:0] throttle,
    output logic        armed,
    output logic        failsafe,
    output logic        cmd_strobe,
    output logic [5:0]  cmd_code,
    output logic        spin_reversed,
    output logic        telem_request
);

    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int CW = $clog2(CMD_REPEAT + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_FRAMES - 1);
    localparam logic [CW-1:0] CMD_FULL = CW'(CMD_REPEAT);

    dshotState_t   state, nextState;
    logic [AW-1:0] armCnt;
    logic [CW-1:0] cmdCnt, cmdCntNext;
    logic [5:0]    prevCmd;
    logic          accepted, isStop, isCmd, cmdCountable, cmdMatch, cmdExec;
    logic          armReach, toExpired;

    assign accepted     = frame_valid && crc_valid;
    assign isStop       = is_special && (cmd_in == CMD_STOP);
    assign isCmd        = is_special && (cmd_in != CMD_STOP) && (cmd_in <= CMD_MAX);
    // Commands only count while the motor is commanded to zero.
    assign cmdCountable = accepted && isCmd && (throttle == 11'd0);
    // A zero count means no sequence is in progress, so any code starts fresh.
    assign cmdMatch     = (cmdCnt != '0) && (cmd_in == prevCmd);
    assign armReach     = (armCnt == ARM_LAST);

    always_comb begin
        cmdCntNext = CW'(1);
        if (cmdMatch)
            cmdCntNext = (cmdCnt == CMD_FULL) ? cmdCnt : cmdCnt + CW'(1);
    end

    // Fires only on the transition into a full count, so held repeats stay quiet.
    assign cmdExec = cmdCountable && (cmdCntNext == CMD_FULL) && (cmdCnt != CMD_FULL);

    dshot_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uTimer (
        .clk    (clk),
        .clear  (reset || accepted || state != ARMED),
        .enable (state == ARMED),
        .expired(toExpired)
    );

    always_comb begin
        nextState = state;
        case (state)
            DISARMED: if (accepted && isStop && armReach) nextState = ARMED;
            // An accepted frame on the expiry cycle wins over the timeout.
            ARMED:    if (!accepted && toExpired)         nextState = FAILSAFE;
            FAILSAFE: if (accepted)                       nextState = DISARMED;
            default:                                      nextState = DISARMED;
        endcase
    end

    assign armed    = (state == ARMED);
    assign failsafe = (state == FAILSAFE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= DISARMED;
            armCnt        <= '0;
            cmdCnt        <= '0;
            prevCmd       <= '0;
            throttle      <= '0;
            cmd_strobe    <= 1'b0;
            cmd_code      <= '0;
            spin_reversed <= 1'b0;
            telem_request <= 1'b0;
        end else begin
            state         <= nextState;
            cmd_strobe    <= 1'b0;
            telem_request <= accepted && telem_in;

            // Arm count restarts on arming and on leaving failsafe.
            if (accepted && state == DISARMED)
                armCnt <= (isStop && !armReach) ? armCnt + AW'(1) : '0;
            else if (accepted && state == FAILSAFE)
                armCnt <= '0;

            if (state == ARMED) begin
                if (accepted)
                    throttle <= is_special ? 11'd0 : clampThrottle(speed_in);
                else if (toExpired)
                    throttle <= 11'd0;
            end else begin
                throttle <= 11'd0;
            end

            if (cmdCountable) begin
                cmdCnt  <= cmdCntNext;
                prevCmd <= cmd_in;
                if (cmdExec) begin
                    cmd_strobe <= 1'b1;
                    cmd_code   <= cmd_in;
                    if (cmd_in == CMD_SPIN_NORMAL)
                        spin_reversed <= 1'b0;
                    else if (cmd_in == CMD_SPIN_REVERSED)
                        spin_reversed <= 1'b1;
                end
            end else if (accepted) begin
                cmdCnt <= '0;
            end
        end
    end

endmodule

// File: doc/dshot_frame_controller.md
DSHOT_FRAME_CONTROLLER -- requirements
Module: dshot_frame_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1600000: clk cycles without a CRC-valid frame before failsafe (100 ms at 16 MHz).
REQ-002 Parameter ARM_FRAMES, default 50: consecutive valid stop frames required to arm.
REQ-003 Parameter CMD_REPEAT, default 6: consecutive identical command frames required to execute a command.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_valid  input  1  one-cycle strobe; decoded fields below are valid this cycle.
REQ-007 crc_valid  input  1  frame CRC correct.
REQ-008 is_special  input  1  frame is command or stop (raw value < 48).
REQ-009 speed_in  input  11  throttle, already offset by -48 (0..1999).
REQ-010 cmd_in  input  6  command code (0 = stop, 1..47 = command).
REQ-011 telem_in  input  1  frame telemetry bit.
REQ-012 throttle  output  11  commanded throttle; 0 unless ARMED.
REQ-013 armed  output  1  high in ARMED.
REQ-014 failsafe  output  1  high in FAILSAFE.
REQ-015 cmd_strobe  output  1  one-cycle pulse when a command executes.
REQ-016 cmd_code  output  6  executed command; held until next execution.
REQ-017 spin_reversed  output  1  spin-direction flag.
REQ-018 telem_request  output  1  one-cycle pulse per accepted frame with telem_in=1.

Function
REQ-019 A frame is accepted only when frame_valid=1 and crc_valid=1; all other cycles are ignored and leave state, counters and outputs unchanged.
REQ-020 The FSM has three states: DISARMED, ARMED, FAILSAFE.
REQ-021 DISARMED: each accepted stop frame (is_special=1, cmd_in=0) increments arm_cnt; any other accepted frame clears arm_cnt; the accepted stop frame that makes arm_cnt reach ARM_FRAMES moves the FSM to ARMED.
REQ-022 ARMED: each accepted non-special frame loads throttle <= speed_in, visible in the cycle after frame_valid (1-cycle latency); an accepted special frame loads throttle <= 0.
REQ-023 ARMED: the timeout counter clears on every accepted frame and increments otherwise; on reaching TIMEOUT_CYCLES, the FSM enters FAILSAFE and throttle <= 0 in the same cycle.
REQ-024 A frame accepted in the same cycle the counter would expire takes priority: the counter clears and no failsafe occurs.
REQ-025 FAILSAFE: throttle stays 0; the first accepted frame moves the FSM to DISARMED with arm_cnt=0 (re-arm required).
REQ-026 Command repeat: an accepted special frame with cmd_in in 1..47 is counted only while throttle=0 (any state); the count increments when cmd_in equals the previous command, otherwise it restarts at 1.
REQ-027 Command execution: cmd_strobe pulses once, and cmd_code updates, on the frame that brings the count to CMD_REPEAT.
REQ-028 After execution, further identical frames do not re-strobe; the count clears on any accepted non-matching frame.
REQ-029 On execution, command 7 clears spin_reversed and command 8 sets it; all other codes only strobe.
REQ-030 The command count saturates at CMD_REPEAT; arm_cnt saturates at ARM_FRAMES; neither counter wraps.

Reset
REQ-031 While reset=1, at the next clk edge: FSM=DISARMED, arm_cnt=0, command count=0, timeout counter=0, throttle=0, armed=0, failsafe=0, cmd_strobe=0, cmd_code=0, spin_reversed=0, telem_request=0.
REQ-032 Reset takes priority over a simultaneous frame_valid; asserting reset mid-operation discards any partial arm or command sequence.

Structure
REQ-033 Shared package dshot_pkg holds: the state enum, CMD_STOP=0, CMD_SPIN_NORMAL=7, CMD_SPIN_REVERSED=8, CMD_MAX=47, THROTTLE_MAX=1999.
REQ-034 The timeout counter is one sub-module, dshot_timeout_timer, with inputs clear and enable and output expired.

Verification (bench parameters: TIMEOUT_CYCLES=1000, ARM_FRAMES=4, CMD_REPEAT=6)
REQ-035 4 stop frames, then speed 1000 -> armed=1 after the 4th frame; throttle=1000 one cycle after the 5th frame_valid.
REQ-036 3 stop frames, one speed-500 frame, 3 stop frames -> armed stays 0.
REQ-037 Armed, no frames for 1000 cycles -> failsafe=1, throttle=0; next accepted frame -> DISARMED; 4 stop frames re-arm.
REQ-038 Armed, 8 consecutive cmd 8 frames at throttle 0 -> exactly one cmd_strobe (on the 6th frame), cmd_code=8, spin_reversed=1.
REQ-039 Frames with crc_valid=0 carrying speed 1500 while armed -> throttle unchanged, and timeout still expires at 1000 cycles.
REQ-040 Accepted frame exactly on the expiry cycle -> no failsafe; reset asserted with frame_valid -> all outputs 0.
